// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP responder running entirely in the clk_i domain: the TCK/TMS/TDI/TRSTn pins are
// oversampled and the IEEE 1149.1 TAP advances on detected TCK edges. Data registers: IDCODE, BYPASS, CONFREG.
module jtag_tap_oversampled #(
    parameter int unsigned          IR_WIDTH      = 5,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h249511C3,
    parameter int unsigned          CONFREG_WIDTH = 9,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE  = 5'h01,
    parameter logic [IR_WIDTH-1:0]  INSTR_CONFREG = 5'h06
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     jtag_tck_i,
    input  logic                     jtag_trst_ni,
    input  logic                     jtag_tms_i,
    input  logic                     jtag_tdi_i,
    output logic                     jtag_tdo_o,
    output logic                     jtag_tdo_en_o,
    output logic [CONFREG_WIDTH-1:0] confreg_o,
    output logic                     confreg_upd_o,
    output logic [3:0]               tap_state_o
);
    localparam int unsigned DR_WIDTH = 32;

    typedef enum logic [3:0] {
        TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
        SHDR  = 4'd4,  EX1DR = 4'd5,  PADR  = 4'd6,  EX2DR = 4'd7,
        UPDR  = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
        EX1IR = 4'd12, PAIR  = 4'd13, EX2IR = 4'd14, UPIR  = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {SEL_BYPASS = 2'd0, SEL_IDCODE = 2'd1, SEL_CONFREG = 2'd2} dr_sel_t;

    logic [2:0]               tck_sync_r;
    logic [1:0]               tms_sync_r;
    logic [1:0]               tdi_sync_r;
    logic [1:0]               trst_sync_r;
    tap_state_t               state_r;
    logic [IR_WIDTH-1:0]      ir_r;
    logic [IR_WIDTH-1:0]      ir_shift_r;
    logic [DR_WIDTH-1:0]      dr_shift_r;
    logic [CONFREG_WIDTH-1:0] confreg_r;
    logic                     confreg_upd_r;
    logic                     tdo_r;
    logic                     tdo_en_r;
    logic                     tck_rise_s;
    logic                     tck_fall_s;
    logic                     tms_s;
    logic                     tdi_s;
    logic                     trst_n_s;
    dr_sel_t                  dr_sel_s;
    logic [DR_WIDTH-1:0]      dr_capture_s;
    logic [DR_WIDTH-1:0]      dr_shifted_s;

    function automatic tap_state_t next_state(input tap_state_t s, input logic t);
        case (s)
            TLR:     next_state = t ? TLR   : RTI;
            RTI:     next_state = t ? SELDR : RTI;
            SELDR:   next_state = t ? SELIR : CAPDR;
            CAPDR:   next_state = t ? EX1DR : SHDR;
            SHDR:    next_state = t ? EX1DR : SHDR;
            EX1DR:   next_state = t ? UPDR  : PADR;
            PADR:    next_state = t ? EX2DR : PADR;
            EX2DR:   next_state = t ? UPDR  : SHDR;
            UPDR:    next_state = t ? SELDR : RTI;
            SELIR:   next_state = t ? TLR   : CAPIR;
            CAPIR:   next_state = t ? EX1IR : SHIR;
            SHIR:    next_state = t ? EX1IR : SHIR;
            EX1IR:   next_state = t ? UPIR  : PAIR;
            PAIR:    next_state = t ? EX2IR : PAIR;
            EX2IR:   next_state = t ? UPIR  : SHIR;
            UPIR:    next_state = t ? SELDR : RTI;
            default: next_state = TLR;
        endcase
    endfunction

    // Two-flop pin synchronizers; the third TCK flop provides the edge reference.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_sync_r  <= 3'b000;
            tms_sync_r  <= 2'b11;
            tdi_sync_r  <= 2'b00;
            trst_sync_r <= 2'b11;
        end else begin
            tck_sync_r  <= {tck_sync_r[1:0], jtag_tck_i};
            tms_sync_r  <= {tms_sync_r[0], jtag_tms_i};
            tdi_sync_r  <= {tdi_sync_r[0], jtag_tdi_i};
            trst_sync_r <= {trst_sync_r[0], jtag_trst_ni};
        end
    end

    assign tck_rise_s = tck_sync_r[1] & ~tck_sync_r[2];
    assign tck_fall_s = ~tck_sync_r[1] & tck_sync_r[2];
    assign tms_s      = tms_sync_r[1];
    assign tdi_s      = tdi_sync_r[1];
    assign trst_n_s   = trst_sync_r[1];

    // Data register selection plus its capture value and one-step shifted value.
    always_comb begin
        dr_capture_s = {DR_WIDTH{1'b0}};
        dr_shifted_s = {DR_WIDTH{1'b0}};
        if (ir_r == INSTR_IDCODE) begin
            dr_sel_s = SEL_IDCODE;
        end else if (ir_r == INSTR_CONFREG) begin
            dr_sel_s = SEL_CONFREG;
        end else begin
            dr_sel_s = SEL_BYPASS;
        end
        case (dr_sel_s)
            SEL_IDCODE: begin
                dr_capture_s = IDCODE_VALUE;
                dr_shifted_s = {tdi_s, dr_shift_r[DR_WIDTH-1:1]};
            end
            SEL_CONFREG: begin
                dr_capture_s[CONFREG_WIDTH-1:0] = confreg_r;
                dr_shifted_s[CONFREG_WIDTH-1:0] = {tdi_s, dr_shift_r[CONFREG_WIDTH-1:1]};
            end
            default: begin
                dr_capture_s = {DR_WIDTH{1'b0}};
                dr_shifted_s[0] = tdi_s;
            end
        endcase
    end

    // TAP state machine with IR/DR actions taken on each TCK rise in the current state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= TLR;
            ir_r          <= INSTR_IDCODE;
            ir_shift_r    <= {IR_WIDTH{1'b0}};
            dr_shift_r    <= {DR_WIDTH{1'b0}};
            confreg_r     <= {CONFREG_WIDTH{1'b0}};
            confreg_upd_r <= 1'b0;
        end else begin
            confreg_upd_r <= 1'b0;
            if (!trst_n_s) begin
                // confreg_r deliberately survives TRSTn; only rst_i clears chip configuration.
                state_r    <= TLR;
                ir_r       <= INSTR_IDCODE;
                ir_shift_r <= {IR_WIDTH{1'b0}};
                dr_shift_r <= {DR_WIDTH{1'b0}};
            end else if (tck_rise_s) begin
                case (state_r)
                    CAPIR:   ir_shift_r <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
                    SHIR:    ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
                    UPIR:    ir_r       <= ir_shift_r;
                    CAPDR:   dr_shift_r <= dr_capture_s;
                    SHDR:    dr_shift_r <= dr_shifted_s;
                    UPDR: begin
                        if (dr_sel_s == SEL_CONFREG) begin
                            confreg_r     <= dr_shift_r[CONFREG_WIDTH-1:0];
                            confreg_upd_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (next_state(state_r, tms_s) == TLR) begin
                    ir_r <= INSTR_IDCODE;
                end
                state_r <= next_state(state_r, tms_s);
            end
        end
    end

    // TDO and its enable change only on TCK falling edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_r    <= 1'b0;
            tdo_en_r <= 1'b0;
        end else if (tck_fall_s) begin
            if (state_r == SHIR) begin
                tdo_r    <= ir_shift_r[0];
                tdo_en_r <= 1'b1;
            end else if (state_r == SHDR) begin
                tdo_r    <= dr_shift_r[0];
                tdo_en_r <= 1'b1;
            end else begin
                tdo_r    <= 1'b0;
                tdo_en_r <= 1'b0;
            end
        end
    end

    assign jtag_tdo_o    = tdo_r;
    assign jtag_tdo_en_o = tdo_en_r;
    assign confreg_o     = confreg_r;
    assign confreg_upd_o = confreg_upd_r;
    assign tap_state_o   = state_r;

endmodule
